// File: rtl/aes_block_sequencer.sv
// rtl/aes_block_sequencer.sv - job engine moving 8-word blocks between memory and aes_coprocessor
// Optional feature: define AES_SEQ_TIMEOUT_EN to bound status polls per block and raise err_out.
module aes_block_sequencer #(
    parameter logic [31:0] AES_BASE    = 32'h0004_0000,
    parameter logic [31:0] IN_OFF      = 32'h0000_0000,
    parameter logic [31:0] OUT_OFF     = 32'h0000_0404,
    parameter logic [31:0] CTRL_OFF    = 32'h0000_1000,
    parameter int          BLOCK_WORDS = 8,
    parameter int          RD_LAT      = 2,
    parameter int          POLL_LIMIT  = 1024
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cfg_src_addr_in,
    input  logic [31:0] cfg_dst_addr_in,
    input  logic [15:0] cfg_len_in,
    input  logic        cfg_mode_in,
    input  logic        start_in,
    input  logic        abort_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        err_out,
    output logic [15:0] blocks_done_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_data_out,
    output logic [3:0]  mem_we_out,
    input  logic [31:0] mem_data_in,
    output logic [31:0] aes_addr_out,
    output logic [31:0] aes_data_out,
    output logic [3:0]  aes_we_out,
    input  logic [31:0] aes_data_in
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_RD, S_LOAD_WR, S_KICK, S_POLL_RD, S_POLL_CHK,
        S_UNLOAD_RD, S_UNLOAD_WR, S_NEXT, S_FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] len_q, len_d;
    logic        mode_q, mode_d;
    logic [15:0] blocks_done_q, blocks_done_d;
    logic [7:0]  word_q, word_d;
    logic [7:0]  lat_q, lat_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [15:0] blocks_inc;
    logic [31:0] word_off;
`ifdef AES_SEQ_TIMEOUT_EN
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        err_q, err_d;
`endif

    localparam logic [7:0] LAT_LAST  = 8'(RD_LAT - 1);
    localparam logic [7:0] WORD_LAST = 8'(BLOCK_WORDS - 1);

    assign word_off = {22'd0, word_q, 2'b00};

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        dst_d         = dst_q;
        len_d         = len_q;
        mode_d        = mode_q;
        blocks_done_d = blocks_done_q;
        word_d        = word_q;
        lat_d         = lat_q;
        rd_data_d     = rd_data_q;
        blocks_inc    = blocks_done_q + {15'd0, (len_q != 16'd0)};
`ifdef AES_SEQ_TIMEOUT_EN
        poll_cnt_d    = poll_cnt_q;
        err_d         = err_q;
`endif
        // Abort wins over everything; counters and captured data simply freeze.
        if (abort_in && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_in) begin
                        src_d         = cfg_src_addr_in;
                        dst_d         = cfg_dst_addr_in;
                        len_d         = cfg_len_in;
                        mode_d        = cfg_mode_in;
                        blocks_done_d = 16'd0;
                        word_d        = 8'd0;
                        lat_d         = 8'd0;
`ifdef AES_SEQ_TIMEOUT_EN
                        err_d         = 1'b0;
`endif
                        // An empty job passes through NEXT once so done still pulses.
                        state_d = (cfg_len_in == 16'd0) ? S_NEXT : S_LOAD_RD;
                    end
                end
                S_LOAD_RD: begin
                    if (lat_q == LAT_LAST) begin
                        rd_data_d = mem_data_in;
                        lat_d     = 8'd0;
                        state_d   = S_LOAD_WR;
                    end else begin
                        lat_d = lat_q + 8'd1;
                    end
                end
                S_LOAD_WR: begin
                    src_d = src_q + 32'd4;
                    if (word_q == WORD_LAST) begin
                        word_d  = 8'd0;
                        state_d = S_KICK;
                    end else begin
                        word_d  = word_q + 8'd1;
                        state_d = S_LOAD_RD;
                    end
                end
                S_KICK: begin
                    lat_d   = 8'd0;
`ifdef AES_SEQ_TIMEOUT_EN
                    poll_cnt_d = 16'd0;
`endif
                    state_d = S_POLL_RD;
                end
                S_POLL_RD: begin
                    if (lat_q == LAT_LAST) begin
                        rd_data_d = aes_data_in;
                        lat_d     = 8'd0;
                        state_d   = S_POLL_CHK;
                    end else begin
                        lat_d = lat_q + 8'd1;
                    end
                end
                S_POLL_CHK: begin
                    if (rd_data_q[2]) begin
                        state_d = S_UNLOAD_RD;
                    end else begin
`ifdef AES_SEQ_TIMEOUT_EN
                        if (poll_cnt_q == 16'(POLL_LIMIT - 1)) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            poll_cnt_d = poll_cnt_q + 16'd1;
                            state_d    = S_POLL_RD;
                        end
`else
                        state_d = S_POLL_RD;
`endif
                    end
                end
                S_UNLOAD_RD: begin
                    if (lat_q == LAT_LAST) begin
                        rd_data_d = aes_data_in;
                        lat_d     = 8'd0;
                        state_d   = S_UNLOAD_WR;
                    end else begin
                        lat_d = lat_q + 8'd1;
                    end
                end
                S_UNLOAD_WR: begin
                    dst_d = dst_q + 32'd4;
                    if (word_q == WORD_LAST) begin
                        word_d  = 8'd0;
                        state_d = S_NEXT;
                    end else begin
                        word_d  = word_q + 8'd1;
                        state_d = S_UNLOAD_RD;
                    end
                end
                S_NEXT: begin
                    blocks_done_d = blocks_inc;
                    state_d       = (blocks_inc == len_q) ? S_FINISH : S_LOAD_RD;
                end
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= S_IDLE;
            src_q         <= '0;
            dst_q         <= '0;
            len_q         <= '0;
            mode_q        <= 1'b0;
            blocks_done_q <= '0;
            word_q        <= '0;
            lat_q         <= '0;
            rd_data_q     <= '0;
`ifdef AES_SEQ_TIMEOUT_EN
            poll_cnt_q    <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            len_q         <= len_d;
            mode_q        <= mode_d;
            blocks_done_q <= blocks_done_d;
            word_q        <= word_d;
            lat_q         <= lat_d;
            rd_data_q     <= rd_data_d;
`ifdef AES_SEQ_TIMEOUT_EN
            poll_cnt_q    <= poll_cnt_d;
            err_q         <= err_d;
`endif
        end
    end

    // Bus outputs decode from registered state only, so reset clears them at once.
    always_comb begin
        mem_addr_out = '0;
        mem_data_out = '0;
        mem_we_out   = '0;
        aes_addr_out = '0;
        aes_data_out = '0;
        aes_we_out   = '0;
        case (state_q)
            S_LOAD_RD: mem_addr_out = src_q;
            S_LOAD_WR: begin
                aes_we_out   = 4'hf;
                aes_addr_out = AES_BASE + IN_OFF + word_off;
                aes_data_out = rd_data_q;
            end
            S_KICK: begin
                aes_we_out   = 4'hf;
                aes_addr_out = AES_BASE + CTRL_OFF;
                aes_data_out = mode_q ? 32'h2 : 32'h1;
            end
            S_POLL_RD, S_POLL_CHK: aes_addr_out = AES_BASE + CTRL_OFF;
            S_UNLOAD_RD: aes_addr_out = AES_BASE + OUT_OFF + word_off;
            S_UNLOAD_WR: begin
                mem_we_out   = 4'hf;
                mem_addr_out = dst_q;
                mem_data_out = rd_data_q;
            end
            default: ;
        endcase
    end

    assign busy_out        = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done_out        = (state_q == S_FINISH);
    assign blocks_done_out = blocks_done_q;
`ifdef AES_SEQ_TIMEOUT_EN
    assign err_out         = err_q;
`else
    assign err_out         = 1'b0;
`endif

endmodule

// File: tb/tb_aes_block_sequencer.sv
// tb/tb_aes_block_sequencer.sv - scoreboard bench with memory and coprocessor behavioural models
module tb_aes_block_sequencer;

    localparam logic [31:0] AES_BASE  = 32'h0004_0000;
    localparam logic [31:0] OUT_BASE  = 32'h0004_0404;
    localparam logic [31:0] CTRL_ADDR = 32'h0004_1000;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [31:0] cfg_src_addr_in = '0;
    logic [31:0] cfg_dst_addr_in = '0;
    logic [15:0] cfg_len_in = '0;
    logic        cfg_mode_in = 1'b0;
    logic        start_in = 1'b0;
    logic        abort_in = 1'b0;
    logic        busy_out, done_out, err_out;
    logic [15:0] blocks_done_out;
    logic [31:0] mem_addr_out, mem_data_out, mem_data_in;
    logic [3:0]  mem_we_out, aes_we_out;
    logic [31:0] aes_addr_out, aes_data_out, aes_data_in;

    always #5 clk_in = ~clk_in;

    aes_block_sequencer dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .cfg_src_addr_in(cfg_src_addr_in), .cfg_dst_addr_in(cfg_dst_addr_in),
        .cfg_len_in(cfg_len_in), .cfg_mode_in(cfg_mode_in),
        .start_in(start_in), .abort_in(abort_in),
        .busy_out(busy_out), .done_out(done_out), .err_out(err_out),
        .blocks_done_out(blocks_done_out),
        .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out), .mem_we_out(mem_we_out),
        .mem_data_in(mem_data_in),
        .aes_addr_out(aes_addr_out), .aes_data_out(aes_data_out), .aes_we_out(aes_we_out),
        .aes_data_in(aes_data_in)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // System memory: source words only; aliases mod 4 KiB so wrapped addresses still resolve.
    logic [31:0] src_mem [1024];
    logic [31:0] mem_rd_q;
    always @(posedge clk_in) mem_rd_q <= src_mem[mem_addr_out[11:2]];
    assign mem_data_in = mem_rd_q;

    // Coprocessor model: done appears a random number of cycles after a kick.
    function automatic logic [31:0] xform(input logic mode, input int i, input logic [31:0] w);
        xform = mode ? ((w ^ 32'h5a5a_5a5a) + 32'(i)) : ({w[15:0], w[31:16]} ^ 32'h0f0f_1234);
    endfunction

    logic [31:0] cp_in [8];
    logic [31:0] cp_out [8];
    logic        cp_done = 1'b0;
    logic        cp_mode = 1'b0;
    int          cp_cnt = 0;
    logic [31:0] aes_rd_q;
    logic [31:0] out_off;
    assign out_off     = aes_addr_out - OUT_BASE;
    assign aes_data_in = aes_rd_q;

    always @(posedge clk_in) begin
        if (aes_addr_out == CTRL_ADDR)       aes_rd_q <= {29'd0, cp_done, 2'b00};
        else if (out_off < 32'd32)           aes_rd_q <= cp_out[out_off[4:2]];
        else                                 aes_rd_q <= 32'hbad0_bad0;
        if (aes_we_out == 4'hf) begin
            if (aes_addr_out == CTRL_ADDR) begin
                cp_mode <= aes_data_out[1];
                cp_done <= 1'b0;
                cp_cnt  <= $urandom_range(1, 7);
            end else if (aes_addr_out - AES_BASE < 32'd32) begin
                cp_in[aes_addr_out[4:2]] <= aes_data_out;
            end
        end else if (cp_cnt != 0) begin
            cp_cnt <= cp_cnt - 1;
            if (cp_cnt == 1) begin
                cp_done <= 1'b1;
                for (int i = 0; i < 8; i++) cp_out[i] <= xform(cp_mode, i, cp_in[i]);
            end
        end
    end

    // Scoreboard queues: {addr, data} for writes, expected block count for done pulses.
    logic [63:0] exp_mem_q [$];
    logic [63:0] exp_aes_q [$];
    logic [15:0] exp_done_q [$];
    int          kick_cnt = 0;

    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk_in);
            if (mem_we_out != 4'h0 && aes_we_out != 4'h0) chk("we_exclusive", 1, 0);
            if (mem_we_out != 4'h0) begin
                chk("mem_we_value", mem_we_out, 4'hf);
                if (exp_mem_q.size() == 0) chk("mem_write_unexpected", {mem_addr_out, mem_data_out}, 0);
                else begin
                    e = exp_mem_q.pop_front();
                    chk("mem_write", {mem_addr_out, mem_data_out}, e);
                end
            end
            if (aes_we_out != 4'h0) begin
                chk("aes_we_value", aes_we_out, 4'hf);
                if (aes_addr_out == CTRL_ADDR) kick_cnt++;
                if (exp_aes_q.size() == 0) chk("aes_write_unexpected", {aes_addr_out, aes_data_out}, 0);
                else begin
                    e = exp_aes_q.pop_front();
                    chk("aes_write", {aes_addr_out, aes_data_out}, e);
                end
            end
            if (done_out) begin
                if (exp_done_q.size() == 0) chk("done_unexpected", 1, 0);
                else chk("done_blocks", blocks_done_out, exp_done_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [31:0] src_word(input logic [31:0] a);
        src_word = src_mem[a[11:2]];
    endfunction

    task automatic push_block(input logic [31:0] src, input logic [31:0] dst, input logic mode, input bit unload);
        for (int i = 0; i < 8; i++)
            exp_aes_q.push_back({AES_BASE + 32'(4 * i), src_word(src + 32'(4 * i))});
        exp_aes_q.push_back({CTRL_ADDR, mode ? 32'h2 : 32'h1});
        if (unload)
            for (int i = 0; i < 8; i++)
                exp_mem_q.push_back({dst + 32'(4 * i), xform(mode, i, src_word(src + 32'(4 * i)))});
    endtask

    task automatic start(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len, input logic mode);
        cfg_src_addr_in = src;
        cfg_dst_addr_in = dst;
        cfg_len_in      = len;
        cfg_mode_in     = mode;
        start_in        = 1'b1;
        tick();
        start_in        = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy_out, 0);
        chk({tag, "_done"}, done_out, 0);
        chk({tag, "_err"}, err_out, 0);
        chk({tag, "_blocks"}, blocks_done_out, 0);
        chk({tag, "_mem_addr"}, mem_addr_out, 0);
        chk({tag, "_mem_data"}, mem_data_out, 0);
        chk({tag, "_mem_we"}, mem_we_out, 0);
        chk({tag, "_aes_addr"}, aes_addr_out, 0);
        chk({tag, "_aes_data"}, aes_data_out, 0);
        chk({tag, "_aes_we"}, aes_we_out, 0);
    endtask

    task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len, input logic mode);
        int n;
        for (int k = 0; k < int'(len); k++)
            push_block(src + 32'(32 * k), dst + 32'(32 * k), mode, 1'b1);
        exp_done_q.push_back(len);
        start(src, dst, len, mode);
        chk("job_busy_after_start", busy_out, 1);
        repeat ($urandom_range(1, 5)) tick();
        cfg_src_addr_in = $urandom;
        cfg_dst_addr_in = $urandom;
        cfg_len_in      = 16'd7;
        cfg_mode_in     = ~mode;
        start_in        = 1'b1;
        tick();
        start_in        = 1'b0;
        n = 0;
        while (busy_out && n < 3000) begin
            tick();
            n++;
        end
        chk("job_completes", busy_out, 0);
        tick();
        chk("job_blocks_done", blocks_done_out, len);
        chk("job_err", err_out, 0);
        chk("job_mem_pending", exp_mem_q.size(), 0);
        chk("job_aes_pending", exp_aes_q.size(), 0);
        chk("job_done_pending", exp_done_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] s, d;
        for (int i = 0; i < 1024; i++) src_mem[i] = $urandom;
        src_mem[32'h100 >> 2] = 32'h6b2e_e973;
        src_mem[32'h104 >> 2] = 32'hc140_3d93;

        repeat (3) tick();
        check_all_zero("reset");
        rst_in = 1'b1;
        tick();
        chk("idle_after_reset", busy_out, 0);

        run_job(32'h100, 32'h200, 16'd1, 1'b0);
        run_job(32'h300, 32'h200, 16'd2, 1'b1);

        // Empty job: busy for one cycle, done two cycles after start, no bus activity.
        exp_done_q.push_back(16'd0);
        start(32'h40, 32'h80, 16'd0, 1'b0);
        chk("len0_busy", busy_out, 1);
        chk("len0_done_early", done_out, 0);
        cfg_len_in = 16'd3;
        start_in   = 1'b1;
        tick();
        chk("len0_done", done_out, 1);
        chk("len0_busy_at_done", busy_out, 0);
        start_in = 1'b0;
        tick();
        chk("len0_start_ignored", busy_out, 0);
        tick();
        chk("len0_still_idle", busy_out, 0);
        chk("len0_blocks", blocks_done_out, 0);
        chk("len0_done_pending", exp_done_q.size(), 0);

        // Address wrap-around at the top of the 32-bit space.
        run_job(32'hffff_fff0, 32'hffff_ffe0, 16'd1, 1'b1);

        for (int j = 0; j < 6; j++) begin
            s = {20'd0, 10'($urandom_range(0, 900)), 2'b00};
            d = $urandom & 32'hffff_fffc;
            run_job(s, d, 16'($urandom_range(1, 3)), 1'($urandom));
        end

        // Abort while polling block 2 of 3.
        s = 32'h500;
        d = 32'h0010_0000;
        push_block(s, d, 1'b0, 1'b1);
        push_block(s + 32'd32, d + 32'd32, 1'b0, 1'b0);
        n = kick_cnt;
        start(s, d, 16'd3, 1'b0);
        begin
            int c;
            c = 0;
            while (!(kick_cnt - n == 2 && aes_addr_out == CTRL_ADDR && aes_we_out == 4'h0) && c < 1000) begin
                tick();
                c++;
            end
            chk("abort_reached_poll", c < 1000, 1);
        end
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        chk("abort_busy", busy_out, 0);
        chk("abort_blocks", blocks_done_out, 1);
        chk("abort_aes_we", aes_we_out, 0);
        chk("abort_mem_we", mem_we_out, 0);
        chk("abort_no_done", done_out, 0);
        repeat (10) tick();
        chk("abort_stays_idle", busy_out, 0);
        chk("abort_mem_pending", exp_mem_q.size(), 0);
        chk("abort_aes_pending", exp_aes_q.size(), 0);

        // Asynchronous reset during a LOAD_WR cycle.
        push_block(32'h600, 32'h700, 1'b1, 1'b1);
        start(32'h600, 32'h700, 16'd2, 1'b1);
        n = 0;
        while (aes_we_out != 4'hf && n < 100) begin
            tick();
            n++;
        end
        chk("reset_found_load_wr", aes_we_out, 4'hf);
        rst_in = 1'b0;
        #1;
        check_all_zero("midjob_reset");
        exp_mem_q.delete();
        exp_aes_q.delete();
        exp_done_q.delete();
        tick();
        tick();
        rst_in = 1'b1;
        tick();
        chk("post_reset_idle", busy_out, 0);
        tick();
        chk("post_reset_no_we", aes_we_out | mem_we_out, 0);

        run_job(32'h180, 32'h280, 16'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
